// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement adder/subtractor with carry-chained ADC/SBC.
// One CHUNK-bit slice is reused each cycle, least significant chunk first.
module addsub_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = $clog2(NCH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             carry_next;
    logic             c_msb;
    logic             last;
    logic [WIDTH-1:0] result_next;

    function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Operands shift right so the active chunk is always at the bottom;
    // finished chunks enter the result from the top.
    assign a_chunk                 = a_reg[CHUNK-1:0];
    assign b_chunk                 = b_reg[CHUNK-1:0];
    assign {carry_next, chunk_sum} = slice_add(a_chunk, b_chunk, carry);
    assign c_msb                   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    assign last                    = (k == KW'(NCH - 1));
    assign result_next             = (result >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            k <= '0;
        end else if (state == RUN) begin
            k      <= k + KW'(1);
            result <= result_next;
            if (last) begin
                c_out    <= carry_next;
                overflow <= c_msb ^ carry_next;
                zero     <= (result_next == '0);
                negative <= result_next[WIDTH-1];
            end
        end
    end

    // Operand and carry registers carry no reset; they are loaded on every acceptance.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_reg <= a;
            b_reg <= op[0] ? ~b : b;
            carry <= op[1] ? c_in : op[0];
        end else if (state == RUN) begin
            a_reg <= a_reg >> CHUNK;
            b_reg <= b_reg >> CHUNK;
            carry <= carry_next;
        end
    end

endmodule
